// File: rtl/cwp_window_ctrl.sv
// ----------------------------------------------------------------------------
// cwp_window_ctrl
// Current Window Pointer manager. Accepts SAVE / RESTORE / TRAP_ENTRY / RETT /
// WRCWP requests, checks the candidate window against the Window Invalid
// Mask, and either commits the new CWP or reports a window trap.
//
// Optional feature macro: CWP_WIN_STATS_EN
//   Defined     -> adds ovf_count_o / unf_count_o saturating trap counters.
//   Not defined -> counters and ports are absent.
//
// Ports:
//   clk_i         system clock, rising edge
//   clr_i         asynchronous active-high reset
//   op_valid_i    request strobe, sampled only while op_ready_o=1
//   op_code_i     0 SAVE, 1 RESTORE, 2 TRAP_ENTRY, 3 RETT, 4 WRCWP, 5-7 reserved
//   wr_cwp_i      new CWP value for WRCWP
//   wim_in_i      Window Invalid Mask from the wim register
//   op_ready_o    idle and able to accept a request
//   done_o        one-cycle completion pulse
//   trap_o        request rejected (valid with done_o)
//   trap_type_o   0 none, 1 window_overflow, 2 window_underflow, 3 illegal
//   cwp_out_o     committed CWP
//   ovf_count_o   (CWP_WIN_STATS_EN) overflow trap count, saturating
//   unf_count_o   (CWP_WIN_STATS_EN) underflow trap count, saturating
// ----------------------------------------------------------------------------
module cwp_window_ctrl #(
  parameter int unsigned NWINDOWS = 8,
  parameter int unsigned CWPW     = 5
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                op_valid_i,
  input  logic [2:0]          op_code_i,
  input  logic [CWPW-1:0]     wr_cwp_i,
  input  logic [NWINDOWS-1:0] wim_in_i,
  output logic                op_ready_o,
  output logic                done_o,
  output logic                trap_o,
  output logic [1:0]          trap_type_o,
`ifdef CWP_WIN_STATS_EN
  output logic [15:0]         ovf_count_o,
  output logic [15:0]         unf_count_o,
`endif
  output logic [CWPW-1:0]     cwp_out_o
);

  localparam logic [2:0] OP_SAVE    = 3'd0;
  localparam logic [2:0] OP_RESTORE = 3'd1;
  localparam logic [2:0] OP_TRAP    = 3'd2;
  localparam logic [2:0] OP_RETT    = 3'd3;
  localparam logic [2:0] OP_WRCWP   = 3'd4;

  localparam logic [1:0] TT_NONE = 2'd0;
  localparam logic [1:0] TT_OVF  = 2'd1;
  localparam logic [1:0] TT_UNF  = 2'd2;
  localparam logic [1:0] TT_ILL  = 2'd3;

  localparam logic [CWPW-1:0] CWP_MAX = CWPW'(NWINDOWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [2:0]      op_code_q;
  logic [CWPW-1:0] wr_cwp_q;
  logic [CWPW-1:0] cwp_q;
  logic            ready_q;
  logic            done_q;
  logic            trap_q;
  logic [1:0]      trap_type_q;

  logic [CWPW-1:0] dec_cwp;
  logic [CWPW-1:0] inc_cwp;
  logic            dec_hit;
  logic            inc_hit;
  logic [CWPW-1:0] cwp_d;
  logic [1:0]      trap_type_d;

  // Candidate windows (modulo NWINDOWS) and the decision for the latched request.
  // wim_in_i is only consumed while in EVAL, so it is effectively sampled once.
  always_comb begin
    dec_cwp     = (cwp_q == '0) ? CWP_MAX : cwp_q - CWPW'(1);
    inc_cwp     = (cwp_q == CWP_MAX) ? '0 : cwp_q + CWPW'(1);
    dec_hit     = |(wim_in_i & (NWINDOWS'(1) << dec_cwp));
    inc_hit     = |(wim_in_i & (NWINDOWS'(1) << inc_cwp));
    cwp_d       = cwp_q;
    trap_type_d = TT_NONE;
    case (op_code_q)
      OP_SAVE: begin
        if (dec_hit) trap_type_d = TT_OVF;
        else         cwp_d       = dec_cwp;
      end
      OP_RESTORE, OP_RETT: begin
        if (inc_hit) trap_type_d = TT_UNF;
        else         cwp_d       = inc_cwp;
      end
      OP_TRAP: begin
        cwp_d = dec_cwp;
      end
      OP_WRCWP: begin
        if (32'(wr_cwp_q) >= NWINDOWS) trap_type_d = TT_ILL;
        else                           cwp_d       = wr_cwp_q;
      end
      default: begin
        trap_type_d = TT_ILL;
      end
    endcase
  end

  // Control FSM: IDLE accepts, EVAL commits the decision, RESP holds done for one cycle.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q     <= ST_IDLE;
      op_code_q   <= 3'd0;
      wr_cwp_q    <= '0;
      cwp_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      trap_q      <= 1'b0;
      trap_type_q <= TT_NONE;
    end else begin
      done_q      <= 1'b0;
      trap_q      <= 1'b0;
      trap_type_q <= TT_NONE;
      case (state_q)
        ST_IDLE: begin
          if (op_valid_i) begin
            op_code_q <= op_code_i;
            wr_cwp_q  <= wr_cwp_i;
            ready_q   <= 1'b0;
            state_q   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          cwp_q       <= cwp_d;
          done_q      <= 1'b1;
          trap_q      <= (trap_type_d != TT_NONE);
          trap_type_q <= trap_type_d;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CWP_WIN_STATS_EN
  logic [15:0] ovf_cnt_q;
  logic [15:0] unf_cnt_q;

  // Saturating trap counters, bumped on the edge that raises done.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      ovf_cnt_q <= 16'd0;
      unf_cnt_q <= 16'd0;
    end else if (state_q == ST_EVAL) begin
      if (trap_type_d == TT_OVF && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (trap_type_d == TT_UNF && unf_cnt_q != 16'hFFFF) unf_cnt_q <= unf_cnt_q + 16'd1;
    end
  end

  assign ovf_count_o = ovf_cnt_q;
  assign unf_count_o = unf_cnt_q;
`endif

  assign op_ready_o  = ready_q;
  assign done_o      = done_q;
  assign trap_o      = trap_q;
  assign trap_type_o = trap_type_q;
  assign cwp_out_o   = cwp_q;

endmodule

// File: tb/tb_cwp_window_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cwp_window_ctrl
// Self-checking bench for cwp_window_ctrl (NWINDOWS=8). Directed scenarios
// follow the window rules; a randomized phase is checked against a modulo
// arithmetic reference model of the CWP and trap counters.
// ----------------------------------------------------------------------------
module tb_cwp_window_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       clr;
  logic       op_valid;
  logic [2:0] op_code;
  logic [4:0] wr_cwp;
  logic [7:0] wim_in;
  logic       op_ready;
  logic       done;
  logic       trap;
  logic [1:0] trap_type;
  logic [4:0] cwp_out;
`ifdef CWP_WIN_STATS_EN
  logic [15:0] ovf_count;
  logic [15:0] unf_count;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_cwp = 0;
  int m_ovf = 0;
  int m_unf = 0;

  cwp_window_ctrl #(.NWINDOWS(8), .CWPW(5)) dut (
    .clk_i       (clk),
    .clr_i       (clr),
    .op_valid_i  (op_valid),
    .op_code_i   (op_code),
    .wr_cwp_i    (wr_cwp),
    .wim_in_i    (wim_in),
    .op_ready_o  (op_ready),
    .done_o      (done),
    .trap_o      (trap),
    .trap_type_o (trap_type),
`ifdef CWP_WIN_STATS_EN
    .ovf_count_o (ovf_count),
    .unf_count_o (unf_count),
`endif
    .cwp_out_o   (cwp_out)
  );

  always #5 clk = ~clk;

  // Spec-level model: returns expected CWP and trap type for one request.
  function automatic void model_op(input int code, input int wr, input logic [7:0] wim,
                                   output int ecwp, output int ett);
    int dec;
    int inc;
    dec  = (m_cwp + N - 1) % N;
    inc  = (m_cwp + 1) % N;
    ecwp = m_cwp;
    ett  = 0;
    case (code)
      0:       if (wim[dec] == 1'b1) ett = 1; else ecwp = dec;
      1, 3:    if (wim[inc] == 1'b1) ett = 2; else ecwp = inc;
      2:       ecwp = dec;
      4:       if (wr >= N) ett = 3; else ecwp = wr;
      default: ett = 3;
    endcase
  endfunction

  // Issues one request and captures the response; lat=-1 means no response.
  task automatic issue(input logic [2:0] code, input logic [4:0] wr, input logic [7:0] wim,
                       output int lat, output logic tr, output logic [1:0] tt,
                       output logic [4:0] cw, output logic rd_eval,
                       output logic dn_next, output logic rd_next);
    int w;
    lat = -1; tr = 1'b0; tt = 2'd0; cw = 5'd0;
    rd_eval = 1'b1; dn_next = 1'b1; rd_next = 1'b0;
    @(negedge clk);
    w = 0;
    while (op_ready !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (op_ready !== 1'b1) return;
    op_valid = 1'b1; op_code = code; wr_cwp = wr; wim_in = wim;
    @(posedge clk);
    #1 op_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) rd_eval = op_ready;
      if (done === 1'b1) begin
        lat = k; tr = trap; tt = trap_type; cw = cwp_out;
        @(negedge clk);
        dn_next = done; rd_next = op_ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; op_valid = 1'b0; op_code = 3'd0; wr_cwp = 5'd0; wim_in = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if (cwp_out !== 5'd0 || op_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_clr cwp=%0d ready=%b exp cwp=0 ready=1", cwp_out, op_ready);
    end
    clr = 1'b0;
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || trap !== 1'b0 || trap_type !== 2'd0 || cwp_out !== 5'd0 || op_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_vals done=%b trap=%b tt=%0d cwp=%0d ready=%b exp 0/0/0/0/1",
               done, trap, trap_type, cwp_out, op_ready);
    end
`ifdef CWP_WIN_STATS_EN
    tests_run++;
    if (ovf_count !== 16'd0 || unf_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_stats ovf=%0d unf=%0d exp 0/0", ovf_count, unf_count);
    end
`endif
    m_cwp = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_save_wrap();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    issue(3'd0, 5'd0, 8'h00, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (lat !== 1 || re !== 1'b0) begin
      tests_failed++;
      $display("FAIL save_wrap_latency lat=%0d ready_in_eval=%b exp lat=1 ready=0", lat, re);
    end
    tests_run++;
    if (tr !== 1'b0 || tt !== 2'd0 || cw !== 5'd7) begin
      tests_failed++;
      $display("FAIL save_wrap_result trap=%b tt=%0d cwp=%0d exp 0/0/7", tr, tt, cw);
    end
    tests_run++;
    if (dn !== 1'b0 || rn !== 1'b1) begin
      tests_failed++;
      $display("FAIL save_wrap_pulse done_next=%b ready_next=%b exp 0/1", dn, rn);
    end
    m_cwp = 7;
  endtask

  task automatic test_overflow();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    issue(3'd0, 5'd0, 8'h40, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (lat !== 1 || tr !== 1'b1 || tt !== 2'd1 || cw !== 5'd7) begin
      tests_failed++;
      $display("FAIL save_overflow lat=%0d trap=%b tt=%0d cwp=%0d exp 1/1/1/7", lat, tr, tt, cw);
    end
    m_ovf++;
    issue(3'd0, 5'd0, 8'h00, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (lat !== 1 || tr !== 1'b0 || tt !== 2'd0 || cw !== 5'd6) begin
      tests_failed++;
      $display("FAIL save_ok lat=%0d trap=%b tt=%0d cwp=%0d exp 1/0/0/6", lat, tr, tt, cw);
    end
    m_cwp = 6;
  endtask

  task automatic test_underflow();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    issue(3'd4, 5'd7, 8'hFF, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (tr !== 1'b0 || cw !== 5'd7) begin
      tests_failed++;
      $display("FAIL wrcwp_7 trap=%b cwp=%0d exp 0/7", tr, cw);
    end
    for (int i = 0; i < 2; i++) begin
      issue((i == 0) ? 3'd1 : 3'd3, 5'd0, 8'h01, lat, tr, tt, cw, re, dn, rn);
      tests_run++;
      if (lat !== 1 || tr !== 1'b1 || tt !== 2'd2 || cw !== 5'd7) begin
        tests_failed++;
        $display("FAIL underflow_%0s lat=%0d trap=%b tt=%0d cwp=%0d exp 1/1/2/7",
                 (i == 0) ? "restore" : "rett", lat, tr, tt, cw);
      end
      m_unf++;
    end
    m_cwp = 7;
  endtask

  task automatic test_trap_entry();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    issue(3'd4, 5'd3, 8'h00, lat, tr, tt, cw, re, dn, rn);
    issue(3'd2, 5'd0, 8'hFF, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (lat !== 1 || tr !== 1'b0 || tt !== 2'd0 || cw !== 5'd2) begin
      tests_failed++;
      $display("FAIL trap_entry_allones lat=%0d trap=%b tt=%0d cwp=%0d exp 1/0/0/2", lat, tr, tt, cw);
    end
    issue(3'd0, 5'd0, 8'hFF, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (tr !== 1'b1 || tt !== 2'd1 || cw !== 5'd2) begin
      tests_failed++;
      $display("FAIL save_allones trap=%b tt=%0d cwp=%0d exp 1/1/2", tr, tt, cw);
    end
    m_ovf++;
    m_cwp = 2;
  endtask

  task automatic test_wrcwp();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    issue(3'd4, 5'd9, 8'h00, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (tr !== 1'b1 || tt !== 2'd3 || cw !== 5'd2) begin
      tests_failed++;
      $display("FAIL wrcwp_9 trap=%b tt=%0d cwp=%0d exp 1/3/2", tr, tt, cw);
    end
    issue(3'd4, 5'd5, 8'hFF, lat, tr, tt, cw, re, dn, rn);
    tests_run++;
    if (tr !== 1'b0 || tt !== 2'd0 || cw !== 5'd5) begin
      tests_failed++;
      $display("FAIL wrcwp_5 trap=%b tt=%0d cwp=%0d exp 0/0/5", tr, tt, cw);
    end
    for (int c = 5; c < 8; c++) begin
      issue(3'(c), 5'd1, 8'h00, lat, tr, tt, cw, re, dn, rn);
      tests_run++;
      if (lat !== 1 || tr !== 1'b1 || tt !== 2'd3 || cw !== 5'd5) begin
        tests_failed++;
        $display("FAIL reserved_op%0d lat=%0d trap=%b tt=%0d cwp=%0d exp 1/1/3/5", c, lat, tr, tt, cw);
      end
    end
    m_cwp = 5;
  endtask

  task automatic test_clr_mid_eval();
    int dones;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; wr_cwp = 5'd0; wim_in = 8'h00;
    @(posedge clk);
    #1 op_valid = 1'b0;
    #2 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (k == 0) begin
        tests_run++;
        if (op_ready !== 1'b1 || cwp_out !== 5'd0) begin
          tests_failed++;
          $display("FAIL clr_eval_state ready=%b cwp=%0d exp 1/0", op_ready, cwp_out);
        end
      end
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL clr_eval_done dones=%0d exp 0", dones);
    end
    m_cwp = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_busy_ignore();
    int dones;
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; wr_cwp = 5'd0; wim_in = 8'h00;
    @(posedge clk);
    #1 op_code = 3'd4; wr_cwp = 5'd3;
    @(posedge clk);
    #1 op_valid = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 1 || cwp_out !== 5'd7) begin
      tests_failed++;
      $display("FAIL busy_ignore dones=%0d cwp=%0d exp 1/7", dones, cwp_out);
    end
    m_cwp = 7;
  endtask

  task automatic test_stats();
`ifdef CWP_WIN_STATS_EN
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cwp = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 2; i++) issue(3'd0, 5'd0, 8'h80, lat, tr, tt, cw, re, dn, rn);
    issue(3'd1, 5'd0, 8'h02, lat, tr, tt, cw, re, dn, rn);
    m_ovf = 2; m_unf = 1;
    tests_run++;
    if (ovf_count !== 16'd2 || unf_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL stats_count ovf=%0d unf=%0d exp 2/1", ovf_count, unf_count);
    end
`endif
  endtask

  // Back-to-back randomized requests against the reference model.
  task automatic test_random();
    int lat; logic tr; logic [1:0] tt; logic [4:0] cw; logic re, dn, rn;
    int r, code, wr, ecwp, ett;
    logic [7:0] wim;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      code = (r < 3) ? 0 : (r < 5) ? 1 : (r == 5) ? 2 : (r == 6) ? 3 : (r == 7) ? 4
           : $urandom_range(4, 7);
      wr = $urandom_range(0, 15);
      r = $urandom_range(0, 3);
      wim = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      model_op(code, wr, wim, ecwp, ett);
      issue(3'(code), 5'(wr), wim, lat, tr, tt, cw, re, dn, rn);
      tests_run++;
      if (lat !== 1 || int'(cw) !== ecwp || int'(tt) !== ett || tr !== (ett != 0)) begin
        tests_failed++;
        $display("FAIL random_%0d op=%0d wr=%0d wim=%h lat=%0d cwp=%0d tt=%0d trap=%b exp lat=1 cwp=%0d tt=%0d",
                 i, code, wr, wim, lat, cw, tt, tr, ecwp, ett);
      end
      m_cwp = ecwp;
      if (ett == 1) m_ovf++;
      if (ett == 2) m_unf++;
    end
`ifdef CWP_WIN_STATS_EN
    tests_run++;
    if (int'(ovf_count) !== m_ovf || int'(unf_count) !== m_unf) begin
      tests_failed++;
      $display("FAIL random_stats ovf=%0d unf=%0d exp %0d/%0d", ovf_count, unf_count, m_ovf, m_unf);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_save_wrap();
    test_overflow();
    test_underflow();
    test_trap_entry();
    test_wrcwp();
    test_clr_mid_eval();
    test_busy_ignore();
    test_stats();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cwp_window_ctrl.md
Name: cwp_window_ctrl

Overview:
- Current Window Pointer (CWP) manager that consumes the Window Invalid Mask register output.
- Executes SAVE, RESTORE, trap entry, RETT and WRPSR-CWP requests from the control unit.
- Checks each candidate window against the mask and commits the new CWP or reports a window trap.
- Sits directly downstream of the wim register; its cwp_out feeds register-file window decode and the PSR read path.

Parameters:
- NWINDOWS, 8, number of register windows; legal range 2..32.
- CWPW, 5, width of the CWP field (PSR[4:0]).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Clr  input  1  reset, asynchronous, active-high.
- op_valid  input  1  request strobe; sampled only while op_ready=1.
- op_code  input  3  request code: 0 SAVE, 1 RESTORE, 2 TRAP_ENTRY, 3 RETT, 4 WRCWP; 5-7 reserved.
- wr_cwp  input  CWPW  new CWP value for WRCWP.
- wim_in  input  NWINDOWS  Window Invalid Mask, driven by the wim register output.
- op_ready  output  1  block idle and able to accept a request.
- done  output  1  one-cycle completion pulse.
- trap  output  1  valid with done; request was rejected.
- trap_type  output  2  valid with done: 0 none, 1 window_overflow, 2 window_underflow, 3 illegal_instruction.
- cwp_out  output  CWPW  committed CWP.

Behaviour:
- Reset values: cwp_out=0, op_ready=1, done=0, trap=0, trap_type=0, FSM=IDLE.
- FSM states: IDLE, EVAL, RESP.
- IDLE: op_ready=1. op_valid=1 latches op_code and wr_cwp, then moves to EVAL.
- EVAL: op_ready=0. Computes the candidate CWP and samples wim_in (one sample only; later wim changes are ignored). Registers the decision, then moves to RESP.
- RESP: done=1 for exactly one cycle. cwp_out updates on the same edge that asserts done. Returns to IDLE.
- Latency: accept edge at cycle 0, done high in cycle 2. Throughput is one request per 3 cycles.
- Candidate CWP arithmetic is modulo NWINDOWS:
  - dec = (CWP==0) ? NWINDOWS-1 : CWP-1.
  - inc = (CWP==NWINDOWS-1) ? 0 : CWP+1.
- SAVE: candidate dec. If wim_in[dec]=1, trap_type=1 and CWP is unchanged; otherwise CWP=dec.
- RESTORE: candidate inc. If wim_in[inc]=1, trap_type=2 and CWP is unchanged; otherwise CWP=inc.
- TRAP_ENTRY: CWP=dec unconditionally; wim_in is not checked; trap=0.
- RETT: same rule as RESTORE (underflow check).
- WRCWP: if wr_cwp >= NWINDOWS, trap_type=3 and CWP is unchanged; otherwise CWP=wr_cwp. wim_in is not checked.
- Reserved op_code: completes with trap=1, trap_type=3, CWP unchanged.
- When trap=1, trap_type is nonzero. When trap=0, trap_type=0. Both are 0 whenever done=0.
- op_valid outside IDLE is ignored and not queued; the requester must hold the request until op_ready=1.
- Clr asserted in any state: immediate return to reset values. A request in flight is discarded and no done is produced.
- wim_in of all ones: every SAVE/RESTORE/RETT traps; TRAP_ENTRY still commits.

Optional Feature:
- Macro: CWP_WIN_STATS_EN.
- Defined: adds output ports ovf_count (16 bits) and unf_count (16 bits).
  - ovf_count increments on each done with trap_type=1; unf_count increments on each done with trap_type=2.
  - Both saturate at 16'hFFFF and are cleared by Clr.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan (NWINDOWS=8):
- Reset, then SAVE with wim_in=8'h00 -> done in cycle 2, trap=0, cwp_out 0->7 (wrap-around).
- cwp_out=7, wim_in=8'h40, SAVE -> trap=1, trap_type=1, cwp_out stays 7. Same state with wim_in=8'h00 -> cwp_out=6.
- cwp_out=7, wim_in=8'h01, RESTORE -> trap_type=2, cwp_out stays 7. Same request as RETT -> identical response.
- cwp_out=3, wim_in=8'hFF, TRAP_ENTRY -> trap=0, cwp_out=2.
- WRCWP wr_cwp=9 -> trap_type=3, CWP unchanged. WRCWP wr_cwp=5 -> cwp_out=5.
- Clr pulsed during EVAL of a SAVE -> no done pulse; cwp_out=0; op_ready=1 next cycle. op_valid asserted during EVAL -> ignored, no extra done. With CWP_WIN_STATS_EN defined, two overflow traps -> ovf_count=2.
